reg_status_file: RTL and testbench

- Architectural register file plus per-register rename status, sitting directly downstream of the reorder buffer's commit port and beside the issue stage.
- Issue reads source operands: each comes back either as a committed value or as the ROB entry that will produce it.
- Issue renames the destination register to a new ROB entry.
- ROB commits write results back and clear the rename when the tag still matches.
- Rollback discards all renames in one cycle.

---
 rtl/reg_status_file.sv | 101 ++++++++++
 tb/tb_reg_status_file.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + producing ROB tag).
// Sources read combinationally with commit bypass; commit, rename and rollback update on the clock.
module reg_status_file #(
    parameter int NREG    = 32,
    parameter int ENTRY_W = 5,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rollback,
    input  logic [4:0]         rs1_idx,
    input  logic [4:0]         rs2_idx,
    output logic               rs1_busy,
    output logic [XLEN-1:0]    rs1_val,
    output logic [ENTRY_W-1:0] rs1_tag,
    output logic               rs2_busy,
    output logic [XLEN-1:0]    rs2_val,
    output logic [ENTRY_W-1:0] rs2_tag,
    input  logic               rename_en,
    input  logic [4:0]         rename_rd,
    input  logic [ENTRY_W-1:0] rename_tag,
    input  logic               commit_sgn,
    input  logic [ENTRY_W-1:0] commit_entry,
    input  logic [5:0]         commit_rd,
    input  logic [XLEN-1:0]    commit_result
);

    logic [NREG-1:0][XLEN-1:0]    val;
    logic [NREG-1:0]              busy;
    logic [NREG-1:0][ENTRY_W-1:0] tag;

    logic [4:0] commit_idx;
    logic       unused_commit_hi;
    logic       commit_hit;

    logic [1:0][4:0]         src_idx;
    logic [1:0]              src_busy;
    logic [1:0][XLEN-1:0]    src_val;
    logic [1:0][ENTRY_W-1:0] src_tag;

    // Bit 5 of the ROB destination field carries no register information here.
    assign commit_idx       = commit_rd[4:0];
    assign unused_commit_hi = commit_rd[5];

    assign commit_hit = commit_sgn && (commit_idx != 5'd0);

    assign src_idx[0] = rs1_idx;
    assign src_idx[1] = rs2_idx;

    // A source waiting on the entry that commits this very cycle is forwarded as ready.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_busy[s] = 1'b0;
            src_val[s]  = '0;
            src_tag[s]  = '0;
            if (src_idx[s] != 5'd0) begin
                src_val[s] = val[src_idx[s]];
                src_tag[s] = tag[src_idx[s]];
                if (busy[src_idx[s]]) begin
                    if (commit_sgn && (commit_idx == src_idx[s]) &&
                        (commit_entry == tag[src_idx[s]])) begin
                        src_val[s] = commit_result;
                    end else begin
                        src_busy[s] = 1'b1;
                    end
                end
            end
        end
    end

    assign rs1_busy = src_busy[0];
    assign rs1_val  = src_val[0];
    assign rs1_tag  = src_tag[0];
    assign rs2_busy = src_busy[1];
    assign rs2_val  = src_val[1];
    assign rs2_tag  = src_tag[1];

    // Later assignments override earlier ones: rollback beats rename, rename beats commit's busy clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val  <= '0;
            busy <= '0;
            tag  <= '0;
        end else if (rdy) begin
            if (commit_hit) begin
                val[commit_idx] <= commit_result;
                if (busy[commit_idx] && (tag[commit_idx] == commit_entry)) begin
                    busy[commit_idx] <= 1'b0;
                end
            end
            if (rollback) begin
                busy <= '0;
            end else if (rename_en && (rename_rd != 5'd0)) begin
                busy[rename_rd] <= 1'b1;
                tag[rename_rd]  <= rename_tag;
            end
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: expected read results are queued as stimulus is
// driven, then popped and compared once the combinational outputs have settled.
module tb_reg_status_file;

    localparam int ENTRY_W = 5;
    localparam int XLEN    = 32;

    logic               clk;
    logic               rst;
    logic               rdy;
    logic               rollback;
    logic [4:0]         rs1_idx;
    logic [4:0]         rs2_idx;
    logic               rs1_busy;
    logic [XLEN-1:0]    rs1_val;
    logic [ENTRY_W-1:0] rs1_tag;
    logic               rs2_busy;
    logic [XLEN-1:0]    rs2_val;
    logic [ENTRY_W-1:0] rs2_tag;
    logic               rename_en;
    logic [4:0]         rename_rd;
    logic [ENTRY_W-1:0] rename_tag;
    logic               commit_sgn;
    logic [ENTRY_W-1:0] commit_entry;
    logic [5:0]         commit_rd;
    logic [XLEN-1:0]    commit_result;

    reg_status_file #(.NREG(32), .ENTRY_W(ENTRY_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_busy(rs1_busy), .rs1_val(rs1_val), .rs1_tag(rs1_tag),
        .rs2_busy(rs2_busy), .rs2_val(rs2_val), .rs2_tag(rs2_tag),
        .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
        .commit_sgn(commit_sgn), .commit_entry(commit_entry),
        .commit_rd(commit_rd), .commit_result(commit_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string              name;
        int                 src;
        logic               busy;
        logic [XLEN-1:0]    val;
        logic               chk_val;
        logic [ENTRY_W-1:0] tag;
        logic               chk_tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_src(input string name, input int src, input logic b,
                              input logic [XLEN-1:0] v, input logic cv,
                              input logic [ENTRY_W-1:0] t, input logic ct);
        exp_t e;
        e.name = name; e.src = src; e.busy = b; e.val = v;
        e.chk_val = cv; e.tag = t; e.chk_tag = ct;
        exp_q.push_back(e);
    endtask

    // Ready source: busy=0 with a known value.
    task automatic exp_ready(input string name, input int src, input logic [XLEN-1:0] v);
        expect_src(name, src, 1'b0, v, 1'b1, '0, 1'b0);
    endtask

    // Pending source: busy=1 with a known producer tag.
    task automatic exp_pend(input string name, input int src, input logic [ENTRY_W-1:0] t);
        expect_src(name, src, 1'b1, '0, 1'b0, t, 1'b1);
    endtask

    task automatic settle_and_check();
        exp_t            e;
        logic            ob;
        logic [XLEN-1:0] ov;
        logic [ENTRY_W-1:0] ot;
        #2;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ob = (e.src == 1) ? rs1_busy : rs2_busy;
            ov = (e.src == 1) ? rs1_val  : rs2_val;
            ot = (e.src == 1) ? rs1_tag  : rs2_tag;
            total++;
            assert (ob === e.busy) else begin
                bad++;
                $error("FAIL %s.busy observed=%0b expected=%0b", e.name, ob, e.busy);
            end
            if (e.chk_val) begin
                total++;
                assert (ov === e.val) else begin
                    bad++;
                    $error("FAIL %s.val observed=%h expected=%h", e.name, ov, e.val);
                end
            end
            if (e.chk_tag) begin
                total++;
                assert (ot === e.tag) else begin
                    bad++;
                    $error("FAIL %s.tag observed=%0d expected=%0d", e.name, ot, e.tag);
                end
            end
        end
    endtask

    task automatic idle_inputs();
        rename_en = 1'b0; rename_rd = '0; rename_tag = '0;
        commit_sgn = 1'b0; commit_entry = '0; commit_rd = '0; commit_result = '0;
        rollback = 1'b0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [ENTRY_W-1:0] t);
        rename_en = 1'b1; rename_rd = rd; rename_tag = t;
    endtask

    task automatic commit(input logic [5:0] rd, input logic [ENTRY_W-1:0] ent,
                          input logic [XLEN-1:0] res);
        commit_sgn = 1'b1; commit_rd = rd; commit_entry = ent; commit_result = res;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; rs1_idx = 5'd5; rs2_idx = 5'd0;
        idle_inputs();

        // Reset state, visible while reset is still held.
        @(negedge clk);
        exp_ready("rst_rs1_x5", 1, 32'h0);
        expect_src("rst_rs2_x0", 2, 1'b0, 32'h0, 1'b1, '0, 1'b1);
        settle_and_check();
        rst = 1'b1;

        // Rename x5 -> tag 3; read in the same cycle still sees the old (ready) state.
        next_cycle();
        rename(5'd5, 5'd3);
        exp_ready("ren_same_cycle_x5", 1, 32'h0);
        settle_and_check();
        next_cycle();
        exp_pend("ren_x5_busy", 1, 5'd3);
        settle_and_check();

        // Commit entry 3 to x5 (bit 5 of commit_rd set, must be ignored): bypass then storage.
        commit(6'h25, 5'd3, 32'hDEADBEEF);
        exp_ready("bypass_x5", 1, 32'hDEADBEEF);
        settle_and_check();
        next_cycle();
        exp_ready("stored_x5", 1, 32'hDEADBEEF);
        settle_and_check();

        // Double rename of x7; the stale commit writes the value but keeps the younger tag.
        rename(5'd7, 5'd2);
        next_cycle();
        rename(5'd7, 5'd9);
        next_cycle();
        rs1_idx = 5'd7;
        commit(6'd7, 5'd2, 32'h11);
        exp_pend("stale_commit_nobypass_x7", 1, 5'd9);
        settle_and_check();
        next_cycle();
        expect_src("stale_commit_x7", 1, 1'b1, 32'h11, 1'b1, 5'd9, 1'b1);
        settle_and_check();
        commit(6'd7, 5'd9, 32'h22);
        exp_ready("bypass_x7", 1, 32'h22);
        settle_and_check();
        next_cycle();
        exp_ready("stored_x7", 1, 32'h22);
        settle_and_check();

        // Commit and rename of x8 on the same edge: rename wins, value still written.
        commit(6'd8, 5'd4, 32'h55);
        rename(5'd8, 5'd6);
        next_cycle();
        rs2_idx = 5'd8;
        expect_src("commit_rename_x8", 2, 1'b1, 32'h55, 1'b1, 5'd6, 1'b1);
        settle_and_check();

        // Rename x1..x3, then rollback with a concurrent rename of x4.
        rename(5'd1, 5'd1);
        next_cycle();
        rename(5'd2, 5'd2);
        next_cycle();
        rename(5'd3, 5'd3);
        next_cycle();
        rs1_idx = 5'd3;
        exp_pend("pre_rollback_x3", 1, 5'd3);
        settle_and_check();
        rollback = 1'b1;
        rename(5'd4, 5'd4);
        next_cycle();
        for (int r = 1; r <= 4; r++) begin
            rs1_idx = r[4:0];
            exp_ready($sformatf("rollback_x%0d", r), 1, 32'h0);
            settle_and_check();
        end
        rs2_idx = 5'd8;
        exp_ready("rollback_x8", 2, 32'h55);
        settle_and_check();

        // Writes to x0 are dropped.
        commit(6'd0, 5'd1, 32'hFFFF);
        rename(5'd0, 5'd7);
        next_cycle();
        rs1_idx = 5'd0; rs2_idx = 5'd0;
        expect_src("x0_rs1", 1, 1'b0, 32'h0, 1'b1, '0, 1'b1);
        expect_src("x0_rs2", 2, 1'b0, 32'h0, 1'b1, '0, 1'b1);
        settle_and_check();

        // rdy low freezes state across a commit to x9 and a rename of x10.
        rdy = 1'b0;
        commit(6'd9, 5'd0, 32'h99);
        rename(5'd10, 5'd5);
        next_cycle();
        rs1_idx = 5'd9; rs2_idx = 5'd10;
        exp_ready("hold_x9", 1, 32'h0);
        exp_ready("hold_x10", 2, 32'h0);
        settle_and_check();
        next_cycle();
        exp_ready("hold2_x9", 1, 32'h0);
        settle_and_check();
        rdy = 1'b1;
        commit(6'd9, 5'd0, 32'h99);
        next_cycle();
        exp_ready("resume_x9", 1, 32'h99);
        settle_and_check();

        // Reset in the middle of a commit and rename clears everything immediately.
        commit(6'd9, 5'd1, 32'h1234);
        rename(5'd11, 5'd2);
        rs2_idx = 5'd5;
        #1 rst = 1'b0;
        exp_ready("midrst_x9", 1, 32'h0);
        exp_ready("midrst_x5", 2, 32'h0);
        settle_and_check();
        next_cycle();
        rst = 1'b1;
        rs1_idx = 5'd11; rs2_idx = 5'd8;
        exp_ready("postrst_x11", 1, 32'h0);
        exp_ready("postrst_x8", 2, 32'h0);
        settle_and_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
